// File: rtl/fp_operand_sequencer.sv
// Button-driven front end for the FP-add demo. It loads two operands byte by byte, hands them to the adder, and shows the sum byte by byte.
// Optional: define FP_CLASS_DISPLAY_EN to add a fifth SHOW step that displays the result's class flags.
module fp_operand_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  ERR_PATTERN    = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_pulse,
  input  logic [7:0]  sw,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        res_valid,
  input  logic [31:0] res,
  output logic [7:0]  led,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    LOAD_A   = 3'd0,
    LOAD_B   = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RES = 3'd3,
    SHOW     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic [2:0]  byte_idx, byte_idx_n;
  logic [31:0] op_a_n, op_b_n, res_q, res_n;
  logic        op_valid_n;
  logic [7:0]  led_n;
  logic [19:0] cnt, cnt_n;

  // Byte i counts from the most significant end.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_of = w[31:24];
      2'd1:    byte_of = w[23:16];
      2'd2:    byte_of = w[15:8];
      default: byte_of = w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (i)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

`ifdef FP_CLASS_DISPLAY_EN
  logic [7:0] class_flags;
  always_comb begin
    class_flags = {3'b000, res_q[31],
                   (res_q[30:23] == 8'hFF) && (res_q[22:0] != '0),
                   (res_q[30:23] == 8'hFF) && (res_q[22:0] == '0),
                   (res_q[30:23] == 8'h00) && (res_q[22:0] == '0),
                   (res_q[30:23] == 8'h00) && (res_q[22:0] != '0)};
  end
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_n    = state;
    byte_idx_n = byte_idx;
    op_a_n     = op_a;
    op_b_n     = op_b;
    op_valid_n = op_valid;
    led_n      = led;
    res_n      = res_q;
    cnt_n      = cnt;
    case (state)
      LOAD_A, LOAD_B: if (btn_pulse) begin
        if (state == LOAD_A) op_a_n = put_byte(op_a, byte_idx[1:0], sw);
        else                 op_b_n = put_byte(op_b, byte_idx[1:0], sw);
        led_n = sw;
        if (byte_idx == 3'd3) begin
          byte_idx_n = 3'd0;
          if (state == LOAD_A) state_n = LOAD_B;
          else begin
            state_n    = ISSUE;
            op_valid_n = 1'b1;
          end
        end else begin
          byte_idx_n = byte_idx + 3'd1;
        end
      end
      ISSUE: if (op_valid && op_ready) begin
        op_valid_n = 1'b0;
        cnt_n      = '0;
        state_n    = WAIT_RES;
      end
      WAIT_RES: begin
        cnt_n = cnt + 20'd1;
        if (res_valid) begin
          res_n      = res;
          led_n      = res[31:24];
          byte_idx_n = 3'd1;
          state_n    = SHOW;
        end else if (cnt == TIMEOUT_LAST) begin
          led_n   = ERR_PATTERN;
          state_n = ERROR;
        end
      end
      SHOW: if (btn_pulse) begin
        case (byte_idx)
          3'd1, 3'd2, 3'd3: begin
            led_n      = byte_of(res_q, byte_idx[1:0]);
            byte_idx_n = byte_idx + 3'd1;
          end
`ifdef FP_CLASS_DISPLAY_EN
          3'd4: begin
            led_n      = class_flags;
            byte_idx_n = 3'd5;
          end
`endif
          default: begin
            op_a_n     = '0;
            op_b_n     = '0;
            byte_idx_n = 3'd0;
            led_n      = 8'h00;
            state_n    = LOAD_A;
          end
        endcase
      end
      ERROR: begin
        led_n = ERR_PATTERN;
        if (btn_pulse) begin
          op_a_n     = '0;
          op_b_n     = '0;
          byte_idx_n = 3'd0;
          state_n    = LOAD_A;
        end
      end
      default: state_n = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= LOAD_A;
      byte_idx <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      led      <= '0;
      res_q    <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      byte_idx <= byte_idx_n;
      op_a     <= op_a_n;
      op_b     <= op_b_n;
      op_valid <= op_valid_n;
      led      <= led_n;
      res_q    <= res_n;
      cnt      <= cnt_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_fp_operand_sequencer.sv
// Directed bench for fp_operand_sequencer covering load, handshake, show, timeout, result/timeout race and mid-load reset.
module tb_fp_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_pulse = 1'b0;
  logic [7:0]  sw = '0;
  logic [31:0] op_a, op_b;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res = '0;
  logic [7:0]  led;
  logic [2:0]  state_o;

  int total = 0;
  int passed = 0;

  fp_operand_sequencer #(.TIMEOUT_CYCLES(16), .ERR_PATTERN(8'hEE)) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .sw(sw),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .res_valid(res_valid), .res(res), .led(led), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; outputs are checked on the falling edge.
  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    sw = b;
    btn_pulse = 1'b1;
    @(negedge clk);
    btn_pulse = 1'b0;
  endtask

  task automatic load8(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) pulse(a[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) pulse(b[31-8*i -: 8]);
  endtask

  task automatic handshake();
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  task automatic reply(input logic [31:0] r);
    @(negedge clk);
    res_valid = 1'b1;
    res = r;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_op_a", op_a, 32'h0);
    check("rst_op_b", op_b, 32'h0);
    check("rst_valid", 32'(op_valid), 32'd0);
    check("rst_led", 32'(led), 32'h0);

    // Byte-wise load, MSB first
    pulse(8'h3F);
    check("load_first_led", 32'(led), 32'h3F);
    check("load_first_op_a", op_a, 32'h3F00_0000);
    @(negedge clk);
    sw = 8'hFF;
    repeat (2) @(negedge clk);
    check("sw_between_presses", op_a, 32'h3F00_0000);
    pulse(8'h80); pulse(8'h00); pulse(8'h00);
    check("to_load_b", 32'(state_o), 32'd1);
    for (int i = 0; i < 4; i++) pulse(i == 0 ? 8'h40 : 8'h00);
    check("issue_op_a", op_a, 32'h3F80_0000);
    check("issue_op_b", op_b, 32'h4000_0000);
    check("issue_valid", 32'(op_valid), 32'd1);
    check("issue_state", 32'(state_o), 32'd2);

    // ISSUE holds for 20 cycles; button presses are ignored
    pulse(8'h12); repeat (5) @(negedge clk);
    pulse(8'h34); repeat (5) @(negedge clk);
    pulse(8'h56); repeat (4) @(negedge clk);
    check("hold_valid", 32'(op_valid), 32'd1);
    check("hold_op_a", op_a, 32'h3F80_0000);
    check("hold_op_b", op_b, 32'h4000_0000);
    check("hold_state", 32'(state_o), 32'd2);
    handshake();
    check("hs_valid", 32'(op_valid), 32'd0);
    check("hs_state", 32'(state_o), 32'd3);

    // Result arrives on the 5th WAIT_RES cycle
    repeat (4) @(negedge clk);
    reply(32'h4040_0000);
    check("show_state", 32'(state_o), 32'd4);
    check("show_b0", 32'(led), 32'h40);
    @(negedge clk); res_valid = 1'b1; res = 32'hDEAD_BEEF;
    @(negedge clk); res_valid = 1'b0;
    check("res_valid_ignored", 32'(led), 32'h40);
    pulse(8'h00); check("show_b1", 32'(led), 32'h40);
    pulse(8'h00); check("show_b2", 32'(led), 32'h00);
    pulse(8'h00); check("show_b3", 32'(led), 32'h00);
`ifdef FP_CLASS_DISPLAY_EN
    pulse(8'h00);
    check("class_normal", 32'(led), 32'h00);
    check("class_state", 32'(state_o), 32'd4);
`endif
    pulse(8'h00);
    check("show_exit_state", 32'(state_o), 32'd0);
    check("show_exit_led", 32'(led), 32'h0);
    check("show_exit_op_a", op_a, 32'h0);

    // Timeout after 16 WAIT_RES cycles
    load8(32'h1111_1111, 32'h2222_2222);
    handshake();
    check("to_wait", 32'(state_o), 32'd3);
    repeat (15) @(negedge clk);
    check("to_not_yet", 32'(state_o), 32'd3);
    @(negedge clk);
    check("to_state", 32'(state_o), 32'd5);
    check("to_led", 32'(led), 32'hEE);
    pulse(8'h00);
    check("err_exit_state", 32'(state_o), 32'd0);
    check("err_exit_op_a", op_a, 32'h0);

    // res_valid in the same cycle the timeout expires wins
    load8(32'h3333_3333, 32'h4444_4444);
    handshake();
    repeat (15) @(negedge clk);
    res_valid = 1'b1;
    res = 32'hC123_4567;
    @(negedge clk);
    res_valid = 1'b0;
    check("race_state", 32'(state_o), 32'd4);
    check("race_led", 32'(led), 32'hC1);
    pulse(8'h00); check("race_b1", 32'(led), 32'h23);
    pulse(8'h00); check("race_b2", 32'(led), 32'h45);
    pulse(8'h00); check("race_b3", 32'(led), 32'h67);
`ifdef FP_CLASS_DISPLAY_EN
    pulse(8'h00);
    check("class_neg_normal", 32'(led), 32'h10);
`endif
    pulse(8'h00);
    check("race_exit", 32'(state_o), 32'd0);

    // Reset after two bytes of op_b, with a press in the same cycle
    for (int i = 0; i < 4; i++) pulse(8'h11 * 8'(i + 1));
    pulse(8'h55); pulse(8'h66);
    check("pre_rst_op_b", op_b, 32'h5566_0000);
    @(negedge clk);
    rst = 1'b1; btn_pulse = 1'b1; sw = 8'h77;
    @(negedge clk);
    rst = 1'b0; btn_pulse = 1'b0;
    check("mid_rst_state", 32'(state_o), 32'd0);
    check("mid_rst_op_a", op_a, 32'h0);
    check("mid_rst_op_b", op_b, 32'h0);
    check("mid_rst_led", 32'(led), 32'h0);
    check("mid_rst_valid", 32'(op_valid), 32'd0);
    pulse(8'hA1);
    check("reload_first", op_a, 32'hA100_0000);
    pulse(8'hA2); pulse(8'hA3); pulse(8'hA4);
    pulse(8'hA5); pulse(8'hA6); pulse(8'hA7); pulse(8'hA8);
    check("reload_op_a", op_a, 32'hA1A2_A3A4);
    check("reload_op_b", op_b, 32'hA5A6_A7A8);
    check("reload_state", 32'(state_o), 32'd2);
    check("reload_valid", 32'(op_valid), 32'd1);

`ifdef FP_CLASS_DISPLAY_EN
    // -Inf class flags on the fifth show press
    handshake();
    reply(32'hFF80_0000);
    pulse(8'h00); pulse(8'h00); pulse(8'h00); pulse(8'h00);
    check("class_neg_inf", 32'(led), 32'h14);
    pulse(8'h00);
    check("class_exit", 32'(state_o), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
